mtr_cmd_slew: RTL and testbench

- Upstream feeder for the PWM generator.
- Converts a signed motor command into an 11-bit `duty` magnitude plus direction enables (`fwd`/`rev`).
- Applies per-period slew limiting. Forces a ramp-down-to-zero and a coast interval before any direction reversal.
- Changes `duty` only on the PWM period boundary (`PWM_synch`), so the PWM never sees a mid-period duty change.

---
 rtl/mtr_cmd_slew.sv | 172 +++++++++++++++++
 tb/tb_mtr_cmd_slew.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_cmd_slew.sv
// Motor command slew limiter: turns a signed command into a duty magnitude
// plus direction enables for the PWM generator. Duty only moves on PWM
// period boundaries, by at most STEP per period, and every direction reversal
// ramps to zero and coasts for COAST_PERIODS full periods first.
module mtr_cmd_slew #(
   parameter logic [10:0] STEP          = 11'd32,
   parameter int unsigned COAST_PERIODS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [11:0] cmd,
   input  logic        cmd_vld,
   input  logic        PWM_synch,
   output logic [10:0] duty,
   output logic        fwd,
   output logic        rev,
   output logic        at_target,
   output logic        busy
);

   localparam int unsigned CW = $clog2(COAST_PERIODS + 1);
   localparam logic [CW-1:0] COAST_LAST = CW'(COAST_PERIODS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      COAST = 2'd2
   } state_t;

   state_t        state;
   logic [10:0]   tgt_mag;
   logic          tgt_dir;     // 0 = forward, 1 = reverse
   logic          cur_dir;
   logic [CW-1:0] coast_cnt;

   logic [11:0]   cmd_abs;
   logic [10:0]   cmd_mag;
   logic [10:0]   eff_mag;
   logic          eff_dir;
   logic [11:0]   duty_w;
   logic [11:0]   step_w;
   logic [11:0]   tgt_w;
   logic [11:0]   up_sum;
   logic [11:0]   down_gap;
   logic [10:0]   toward;
   logic [10:0]   ramp_down;
   logic [10:0]   first_duty;

   // Effective target for this cycle and the candidate slew-limited duty values.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      cmd_abs    = cmd[11] ? (12'd0 - cmd) : cmd;
      cmd_mag    = cmd_abs[11] ? 11'h7FF : cmd_abs[10:0];   // -2048 saturates to 2047
      eff_mag    = cmd_vld ? cmd_mag : tgt_mag;
      eff_dir    = (cmd_vld && (cmd != 12'd0)) ? cmd[11] : tgt_dir;

      // 12-bit arithmetic so duty+STEP cannot wrap.
      duty_w     = {1'b0, duty};
      step_w     = {1'b0, STEP};
      tgt_w      = {1'b0, eff_mag};
      up_sum     = duty_w + step_w;
      down_gap   = duty_w - tgt_w;

      toward     = duty;
      if (duty_w < tgt_w) begin
         toward = (up_sum >= tgt_w) ? eff_mag : up_sum[10:0];
      end else if (duty_w > tgt_w) begin
         toward = (down_gap <= step_w) ? eff_mag : (duty - STEP);
      end

      ramp_down  = (duty_w <= step_w) ? 11'd0 : (duty - STEP);
      first_duty = (step_w < tgt_w) ? STEP : eff_mag;
   end

   // Target latch plus the run/coast state machine with registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state     <= IDLE;
         tgt_mag   <= 11'd0;
         tgt_dir   <= 1'b0;
         cur_dir   <= 1'b0;
         coast_cnt <= '0;
         duty      <= 11'd0;
         fwd       <= 1'b0;
         rev       <= 1'b0;
         at_target <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (cmd_vld) begin
            tgt_mag <= cmd_mag;
            if (cmd != 12'd0) begin
               tgt_dir <= cmd[11];
            end
         end

         if (!en) begin
            // Drop is immediate, not period-gated; targets are kept.
            state     <= IDLE;
            coast_cnt <= '0;
            duty      <= 11'd0;
            fwd       <= 1'b0;
            rev       <= 1'b0;
            at_target <= 1'b0;
            busy      <= 1'b0;
         end else if (PWM_synch) begin
            case (state)
               IDLE: begin
                  state     <= RUN;
                  cur_dir   <= eff_dir;
                  duty      <= first_duty;
                  fwd       <= ~eff_dir;
                  rev       <= eff_dir;
                  at_target <= (first_duty == eff_mag);
                  busy      <= (first_duty != eff_mag);
               end

               RUN: begin
                  if ((cur_dir == eff_dir) || (eff_mag == 11'd0)) begin
                     duty      <= toward;
                     fwd       <= ~cur_dir;
                     rev       <= cur_dir;
                     at_target <= (toward == eff_mag);
                     busy      <= (toward != eff_mag);
                  end else if (ramp_down == 11'd0) begin
                     // Reached zero against the new direction: start coasting.
                     state     <= COAST;
                     coast_cnt <= '0;
                     duty      <= 11'd0;
                     fwd       <= 1'b0;
                     rev       <= 1'b0;
                     at_target <= 1'b0;
                     busy      <= 1'b1;
                  end else begin
                     duty      <= ramp_down;
                     fwd       <= ~cur_dir;
                     rev       <= cur_dir;
                     at_target <= 1'b0;
                     busy      <= 1'b1;
                  end
               end

               COAST: begin
                  coast_cnt <= coast_cnt + 1'b1;
                  if (coast_cnt == COAST_LAST) begin
                     // Coast always completes, even if the target flipped back.
                     state     <= RUN;
                     cur_dir   <= eff_dir;
                     duty      <= first_duty;
                     fwd       <= ~eff_dir;
                     rev       <= eff_dir;
                     at_target <= (first_duty == eff_mag);
                     busy      <= (first_duty != eff_mag);
                  end
               end

               default: begin
                  state     <= IDLE;
                  duty      <= 11'd0;
                  fwd       <= 1'b0;
                  rev       <= 1'b0;
                  at_target <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mtr_cmd_slew.sv
// Bench for mtr_cmd_slew: an integer-arithmetic model of the slew rules is
// compared against the DUT every cycle, and directed literal checks pin the
// model to hand-computed values.
module tb_mtr_cmd_slew;

   localparam int STEP  = 32;
   localparam int COAST = 2;
   localparam int GAP   = 7;     // idle clocks between PWM period pulses

   logic        clk;
   logic        rst;
   logic        en;
   logic [11:0] cmd;
   logic        cmd_vld;
   logic        PWM_synch;
   logic [10:0] duty;
   logic        fwd;
   logic        rev;
   logic        at_target;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;
   bit chk_en = 0;

   mtr_cmd_slew #(.STEP(11'd32), .COAST_PERIODS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cmd       (cmd),
      .cmd_vld   (cmd_vld),
      .PWM_synch (PWM_synch),
      .duty      (duty),
      .fwd       (fwd),
      .rev       (rev),
      .at_target (at_target),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_mode: 0 = off, 1 = driving, 2 = coasting
   int m_mode = 0, m_duty = 0, m_tmag = 0, m_tdir = 0, m_cdir = 0, m_coast = 0;
   int e_duty = 0, e_fwd = 0, e_rev = 0, e_at = 0, e_busy = 0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic publish();
      bit on;
      on     = (m_mode == 1);
      e_duty = on ? m_duty : 0;
      e_fwd  = (on && m_cdir == 0) ? 1 : 0;
      e_rev  = (on && m_cdir == 1) ? 1 : 0;
      e_at   = (on && m_duty == m_tmag && (m_cdir == m_tdir || m_tmag == 0)) ? 1 : 0;
      e_busy = (m_mode == 2 || (on && e_at == 0)) ? 1 : 0;
   endtask

   always @(posedge clk) begin
      int c;
      if (rst) begin
         m_mode = 0; m_duty = 0; m_tmag = 0; m_tdir = 0; m_cdir = 0; m_coast = 0;
         publish();
      end else begin
         if (cmd_vld) begin
            c = $signed(cmd);
            m_tmag = imin((c < 0) ? -c : c, 2047);
            if (c != 0) m_tdir = (c < 0) ? 1 : 0;
         end
         if (!en) begin
            m_mode = 0; m_duty = 0; m_coast = 0;
            publish();
         end else if (PWM_synch) begin
            if (m_mode == 0) begin
               m_mode = 1; m_cdir = m_tdir; m_duty = imin(STEP, m_tmag);
            end else if (m_mode == 1) begin
               if (m_cdir == m_tdir || m_tmag == 0) begin
                  if (m_duty < m_tmag) m_duty = imin(m_duty + STEP, m_tmag);
                  else                 m_duty = imax(m_duty - STEP, m_tmag);
               end else begin
                  m_duty = imax(m_duty - STEP, 0);
                  if (m_duty == 0) begin
                     m_mode = 2; m_coast = 0;
                  end
               end
            end else begin
               m_coast++;
               if (m_coast == COAST) begin
                  m_mode = 1; m_cdir = m_tdir; m_duty = imin(STEP, m_tmag);
               end
            end
            publish();
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_duty", 32'(duty), e_duty);
         check("cyc_fwd", 32'(fwd), e_fwd);
         check("cyc_rev", 32'(rev), e_rev);
         check("cyc_at_target", 32'(at_target), e_at);
         check("cyc_busy", 32'(busy), e_busy);
         check("cyc_no_overlap", 32'(fwd & rev), 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic s, input logic v, input logic [11:0] c);
      PWM_synch = s;
      cmd_vld   = v;
      cmd       = c;
      @(negedge clk);
      PWM_synch = 1'b0;
      cmd_vld   = 1'b0;
   endtask

   task automatic synch_n(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 12'd0);
         repeat (GAP) @(negedge clk);
      end
   endtask

   task automatic chk_out(input string name, input int d, input int f, input int r,
                          input int a, input int b);
      check({name, "_duty"}, 32'(duty), d);
      check({name, "_fwd"}, 32'(fwd), f);
      check({name, "_rev"}, 32'(rev), r);
      check({name, "_at"}, 32'(at_target), a);
      check({name, "_busy"}, 32'(busy), b);
   endtask

   initial begin
      int ramp_exp [4];
      int guard;
      ramp_exp = '{32, 64, 96, 100};

      rst = 1'b1; en = 1'b0; cmd = 12'd0; cmd_vld = 1'b0; PWM_synch = 1'b0;
      repeat (2) @(negedge clk);
      chk_out("reset", 0, 0, 0, 0, 0);
      chk_en = 1;
      rst = 1'b0;
      en  = 1'b1;
      @(negedge clk);

      // Ramp up to +100.
      cyc(1'b0, 1'b1, 12'd100);
      for (int k = 0; k < 4; k++) begin
         synch_n(1);
         check("ramp_duty", 32'(duty), ramp_exp[k]);
         check("ramp_fwd", 32'(fwd), 1);
      end
      check("ramp_at", 32'(at_target), 1);
      check("ramp_busy", 32'(busy), 0);

      // Reversal to -64 through a full coast.
      cyc(1'b0, 1'b1, 12'hFC0);
      synch_n(1); chk_out("rev1", 68, 1, 0, 0, 1);
      synch_n(1); check("rev2_duty", 32'(duty), 36);
      synch_n(1); check("rev3_duty", 32'(duty), 4);
      synch_n(1); chk_out("rev_coast1", 0, 0, 0, 0, 1);
      synch_n(1); chk_out("rev_coast2", 0, 0, 0, 0, 1);
      synch_n(1); chk_out("rev_run1", 32, 0, 1, 0, 1);
      synch_n(1); chk_out("rev_run2", 64, 0, 1, 1, 0);

      // Back to +100 forward, bounded wait on at_target.
      cyc(1'b0, 1'b1, 12'd100);
      guard = 0;
      do begin
         synch_n(1);
         guard++;
      end while (!(at_target === 1'b1 && fwd === 1'b1) && guard < 20);
      check("back_fwd_timeout", 32'(guard < 20), 1);
      check("back_fwd_duty", 32'(duty), 100);

      // Same-cycle cmd_vld and synch uses the new target.
      cyc(1'b1, 1'b1, 12'd40);
      chk_out("simul", 68, 1, 0, 0, 1);
      repeat (GAP) @(negedge clk);
      // cmd_vld without synch leaves the outputs alone.
      cyc(1'b0, 1'b1, 12'd10);
      repeat (5) @(negedge clk);
      chk_out("gated", 68, 1, 0, 0, 1);
      synch_n(1); check("gated_step1", 32'(duty), 36);
      synch_n(1); chk_out("gated_step2", 10, 1, 0, 1, 0);

      // Saturation from IDLE with cmd = -2048.
      en = 1'b0;
      @(negedge clk);
      chk_out("en_off", 0, 0, 0, 0, 0);
      cyc(1'b0, 1'b1, 12'h800);
      en = 1'b1;
      synch_n(63);
      chk_out("sat63", 2016, 0, 1, 0, 1);
      synch_n(1);
      chk_out("sat64", 2047, 0, 1, 1, 0);

      // Enable drop mid-coast, then restart without an extra coast.
      en = 1'b0;
      @(negedge clk);
      cyc(1'b0, 1'b1, 12'd40);
      en = 1'b1;
      synch_n(2);
      chk_out("en6_fwd", 40, 1, 0, 1, 0);
      cyc(1'b0, 1'b1, 12'hFD8);
      synch_n(2);
      chk_out("en6_coast", 0, 0, 0, 0, 1);
      synch_n(1);
      en = 1'b0;
      @(negedge clk);
      chk_out("en6_drop", 0, 0, 0, 0, 0);
      en = 1'b1;
      @(negedge clk);
      synch_n(1);
      chk_out("en6_restart", 32, 0, 1, 0, 1);

      // Reset mid-ramp clears targets as well as outputs.
      cyc(1'b0, 1'b1, 12'hF9C);
      synch_n(1);
      check("pre_rst_duty", 32'(duty), 64);
      rst = 1'b1;
      @(negedge clk);
      chk_out("mid_rst", 0, 0, 0, 0, 0);
      rst = 1'b0;
      synch_n(1);
      chk_out("post_rst", 0, 1, 0, 1, 0);

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
